// File: rtl/enc_arbiter.sv
// enc_arbiter: round-robin bit-serial channel arbiter with codeblock channel-ID FIFO; define ENC_ARB_FIXED_PRIO_EN for lowest-index priority
module enc_arbiter #(
  parameter int N_CH = 4,
  parameter int K_BITS = 7136,
  parameter int ID_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         s_axis_tdata,
  input  logic [N_CH-1:0]         s_axis_tvalid,
  output logic [N_CH-1:0]         s_axis_tready,
  output logic                    enc_tdata,
  output logic                    enc_tvalid,
  input  logic                    enc_tready,
  input  logic                    enc_out_tvalid,
  input  logic                    enc_out_tready,
  input  logic                    enc_out_tlast,
  output logic [$clog2(N_CH)-1:0] m_id,
  output logic                    m_id_valid,
  output logic                    busy,
  output logic                    err_underflow
);
  localparam int IW = $clog2(N_CH);
  localparam int CW = $clog2(K_BITS);
  localparam int PW = $clog2(ID_DEPTH);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [IW-1:0] g, last_grant, winner, idx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] mem [ID_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic full, empty, push, pop_req, pop, hs, last_bit;
`ifdef ENC_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = IW'(i);
      if (s_axis_tvalid[idx]) winner = idx;
    end
  end
`else
  // scanned from lowest to highest priority so the closest requester after last_grant wins
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = IW'((int'(last_grant) + i) % N_CH);
      if (s_axis_tvalid[idx]) winner = idx;
    end
  end
`endif
  assign full = count == (PW+1)'(ID_DEPTH);
  assign empty = count == '0;
  assign push = state == IDLE && |s_axis_tvalid && !full;
  assign pop_req = enc_out_tvalid && enc_out_tready && enc_out_tlast;
  assign pop = pop_req && !empty;
  assign hs = state == STREAM && enc_tvalid && enc_tready;
  assign last_bit = cnt == CW'(K_BITS - 1);
  assign busy = state == STREAM;
  assign enc_tdata = busy && s_axis_tdata[g];
  assign enc_tvalid = busy && s_axis_tvalid[g];
  assign s_axis_tready = busy ? (N_CH'(enc_tready) << g) : '0;
  assign m_id_valid = !empty;
  assign m_id = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= winner;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      last_grant <= IW'(N_CH - 1);
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (pop_req && empty) err_underflow <= 1'b1;
      if (push) begin
        g <= winner;
        state <= STREAM;
      end
      if (hs) begin
        cnt <= last_bit ? '0 : cnt + CW'(1);
        if (last_bit) begin
          last_grant <= g;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_enc_arbiter.sv
// tb_enc_arbiter: scoreboard bench for enc_arbiter with a short codeblock length
module tb_enc_arbiter;
  localparam int N = 4, K = 256, D = 4, LIM = 20 * K;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] s_axis_tdata = '0, s_axis_tvalid = '0, s_axis_tready;
  logic enc_tdata, enc_tvalid, enc_tready = 1'b0;
  logic enc_out_tvalid = 1'b0, enc_out_tready = 1'b0, enc_out_tlast = 1'b0;
  logic [1:0] m_id;
  logic m_id_valid, busy, err_underflow;
  int n_chk = 0, n_fail = 0;
  int bits, blocks_done, idle_run, leak, lock_err, data_err, hs_total, tb_last, blk_g;
  int exp_q[$], exp_id_q[$], obs_q[$], gap_q[$];

  enc_arbiter #(.N_CH(N), .K_BITS(K), .ID_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .enc_tdata(enc_tdata), .enc_tvalid(enc_tvalid), .enc_tready(enc_tready),
    .enc_out_tvalid(enc_out_tvalid), .enc_out_tready(enc_out_tready), .enc_out_tlast(enc_out_tlast),
    .m_id(m_id), .m_id_valid(m_id_valid), .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic int rr(input int last, input logic [N-1:0] req);
`ifdef ENC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (req[2'(i)]) return i;
`else
    for (int i = 1; i <= N; i++) begin
      int c = (last + i) % N;
      if (req[2'(c)]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic expect_grants(input logic [N-1:0] req, input int n);
    for (int i = 0; i < n; i++) begin
      int w = rr(tb_last, req);
      exp_q.push_back(w);
      exp_id_q.push_back(w);
      tb_last = w;
    end
  endtask

  task automatic clear_model();
    bits = 0; blocks_done = 0; idle_run = 0; leak = 0; lock_err = 0; data_err = 0; hs_total = 0;
    tb_last = N - 1; blk_g = -1;
    exp_q.delete(); exp_id_q.delete(); obs_q.delete(); gap_q.delete();
  endtask

  // records what the DUT did this cycle; judgements are made by the tests
  task automatic observe();
    int ch = -1;
    for (int i = N - 1; i >= 0; i--) if (s_axis_tready[2'(i)]) ch = i;
    if ($countones(s_axis_tready) > 1 || (!busy && (s_axis_tready != 0 || enc_tvalid || enc_tdata))) leak++;
    if (!busy && bits != 0) lock_err++;
    if (busy && enc_tvalid && enc_tready) begin
      if (ch < 0) lock_err++;
      else if (enc_tdata !== s_axis_tdata[2'(ch)]) data_err++;
      if (bits == 0) begin
        obs_q.push_back(ch);
        blk_g = ch;
        if (blocks_done > 0) gap_q.push_back(idle_run);
      end else if (ch != blk_g) lock_err++;
      bits++; hs_total++;
      if (bits == K) begin bits = 0; blocks_done++; idle_run = 0; end
    end else if (!busy) idle_run++;
  endtask

  task automatic step();
    s_axis_tdata = 4'($urandom);
    #1 observe();
    @(negedge clk);
  endtask

  task automatic set_pop(input logic v);
    enc_out_tvalid = v; enc_out_tready = v; enc_out_tlast = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_axis_tvalid = '0; enc_tready = 1'b0; set_pop(1'b0);
    step(); step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_axis_tvalid = '1; enc_tready = 1'b1; set_pop(1'b1);
    step(); step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (s_axis_tready !== 4'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0000", s_axis_tready); end
    n_chk++; if (enc_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_enc_tvalid: got %b want 0", enc_tvalid); end
    n_chk++; if (enc_tdata !== 1'b0) begin n_fail++; $display("FAIL reset_enc_tdata: got %b want 0", enc_tdata); end
    n_chk++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_id_valid: got %b want 0", m_id_valid); end
    n_chk++; if (m_id !== 2'd0) begin n_fail++; $display("FAIL reset_m_id: got %0d want 0", m_id); end
    n_chk++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    rst = 1'b0; set_pop(1'b0); s_axis_tvalid = '0; enc_tready = 1'b0;
    clear_model();
  endtask

  task automatic test_round_robin();
    int pops = 0, e, o;
    do_reset();
    expect_grants(4'hF, 5);
    s_axis_tvalid = 4'hF; enc_tready = 1'b1;
    for (int c = 0; c < LIM && blocks_done < 5; c++) begin
      set_pop(blocks_done > pops && m_id_valid);
      if (enc_out_tlast) begin
        e = exp_id_q.pop_front(); pops++;
        n_chk++; if (m_id !== 2'(e)) begin n_fail++; $display("FAIL rr_m_id: got %0d want %0d", m_id, e); end
      end
      step();
    end
    s_axis_tvalid = '0; set_pop(1'b0);
    n_chk++; if (blocks_done != 5) begin n_fail++; $display("FAIL rr_blocks: got %0d want 5", blocks_done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++; if (o != e) begin n_fail++; $display("FAIL rr_grant: got ch%0d want ch%0d", o, e); end
    end
    n_chk++; if (gap_q.size() != 4) begin n_fail++; $display("FAIL rr_gap_count: got %0d want 4", gap_q.size()); end
    while (gap_q.size() > 0) begin
      o = gap_q.pop_front();
      n_chk++; if (o != 1) begin n_fail++; $display("FAIL rr_idle_gap: got %0d want 1", o); end
    end
    n_chk++; if (leak != 0) begin n_fail++; $display("FAIL rr_leak: got %0d want 0", leak); end
    n_chk++; if (lock_err != 0) begin n_fail++; $display("FAIL rr_lock: got %0d want 0", lock_err); end
    n_chk++; if (data_err != 0) begin n_fail++; $display("FAIL rr_data: got %0d want 0", data_err); end
  endtask

  task automatic test_stall();
    int e, o = -1;
    logic [N-1:0] others = '0;
    do_reset();
    expect_grants(4'b0100, 1);
    s_axis_tvalid = 4'b0100;
    for (int c = 0; c < LIM && blocks_done < 1; c++) begin
      enc_tready = (c % 2 == 0);
      step();
      others |= s_axis_tready & 4'b1011;
    end
    s_axis_tvalid = '0;
    e = exp_q.pop_front();
    if (obs_q.size() > 0) o = obs_q.pop_front();
    n_chk++; if (o != e) begin n_fail++; $display("FAIL stall_grant: got ch%0d want ch%0d", o, e); end
    n_chk++; if (hs_total != K) begin n_fail++; $display("FAIL stall_bits: got %0d want %0d", hs_total, K); end
    n_chk++; if (others !== 4'b0) begin n_fail++; $display("FAIL stall_other_ready: got %b want 0000", others); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_end_idle: got %b want 0", busy); end
    n_chk++; if (m_id !== 2'd2) begin n_fail++; $display("FAIL stall_m_id: got %0d want 2", m_id); end
    n_chk++; if (lock_err != 0 || data_err != 0) begin n_fail++; $display("FAIL stall_lock: got %0d/%0d want 0/0", lock_err, data_err); end
  endtask

  task automatic test_hold();
    int dropped = 0, hold_err = 0, e, o;
    do_reset();
    expect_grants(4'b1010, 2);
    s_axis_tvalid = 4'b1010; enc_tready = 1'b1;
    for (int c = 0; c < LIM && blocks_done < 2; c++) begin
      if (blocks_done == 0 && bits == 100 && dropped < 50) begin s_axis_tvalid[1] = 1'b0; dropped++; end
      else s_axis_tvalid[1] = 1'b1;
      step();
      if (!s_axis_tvalid[1] && (!busy || s_axis_tready[3] || enc_tvalid)) hold_err++;
    end
    s_axis_tvalid = '0;
    n_chk++; if (blocks_done != 2) begin n_fail++; $display("FAIL hold_blocks: got %0d want 2", blocks_done); end
    n_chk++; if (dropped != 50) begin n_fail++; $display("FAIL hold_dropped: got %0d want 50", dropped); end
    n_chk++; if (hold_err != 0) begin n_fail++; $display("FAIL hold_stall: got %0d want 0", hold_err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++; if (o != e) begin n_fail++; $display("FAIL hold_grant: got ch%0d want ch%0d", o, e); end
    end
    n_chk++; if (lock_err != 0) begin n_fail++; $display("FAIL hold_lock: got %0d want 0", lock_err); end
  endtask

  task automatic test_fifo_full();
    int idle_err = 0, e, o;
    do_reset();
    expect_grants(4'hF, 5);
    s_axis_tvalid = 4'hF; enc_tready = 1'b1;
    for (int c = 0; c < LIM && blocks_done < 4; c++) step();
    repeat (10) begin
      step();
      if (busy || s_axis_tready != 0) idle_err++;
    end
    n_chk++; if (blocks_done != 4) begin n_fail++; $display("FAIL full_blocks: got %0d want 4", blocks_done); end
    n_chk++; if (idle_err != 0) begin n_fail++; $display("FAIL full_no_grant: got %0d want 0", idle_err); end
    n_chk++; if (m_id_valid !== 1'b1 || m_id !== 2'd0) begin n_fail++; $display("FAIL full_head: got %b/%0d want 1/0", m_id_valid, m_id); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front(); o = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++; if (o != e) begin n_fail++; $display("FAIL full_grant: got ch%0d want ch%0d", o, e); end
    end
    set_pop(1'b1); step(); set_pop(1'b0);
    n_chk++; if (busy !== 1'b0 || m_id !== 2'd1) begin n_fail++; $display("FAIL full_after_pop: got busy=%b id=%0d want busy=0 id=1", busy, m_id); end
    step();
    e = exp_q.pop_front();
    n_chk++; if (busy !== 1'b1 || s_axis_tready !== 4'(1 << e)) begin n_fail++; $display("FAIL full_fifth_grant: got busy=%b tready=%b want busy=1 tready=%b", busy, s_axis_tready, 4'(1 << e)); end
    s_axis_tvalid = '0;
  endtask

  task automatic test_underflow_reset();
    int e, o;
    do_reset();
    set_pop(1'b1); step(); set_pop(1'b0);
    n_chk++; if (err_underflow !== 1'b1 || m_id_valid !== 1'b0) begin n_fail++; $display("FAIL uf_flag: got err=%b valid=%b want 1/0", err_underflow, m_id_valid); end
    step();
    n_chk++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
    enc_tready = 1'b1;
    expect_grants(4'b0010, 1);
    s_axis_tvalid = 4'b0010;
    for (int c = 0; c < LIM && blocks_done < 1; c++) step();
    expect_grants(4'b0100, 1);
    s_axis_tvalid = 4'b0100;
    for (int c = 0; c < LIM && bits < 150; c++) step();
    n_chk++; if (bits != 150 || busy !== 1'b1) begin n_fail++; $display("FAIL uf_mid_block: got bits=%0d busy=%b want 150/1", bits, busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++; if (o != e) begin n_fail++; $display("FAIL uf_grant: got ch%0d want ch%0d", o, e); end
    end
    rst = 1'b1; step();
    n_chk++; if (busy !== 1'b0 || s_axis_tready !== 4'b0 || enc_tvalid !== 1'b0 || enc_tdata !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_stream: got busy=%b tready=%b v=%b d=%b want 0", busy, s_axis_tready, enc_tvalid, enc_tdata); end
    n_chk++; if (m_id_valid !== 1'b0 || m_id !== 2'd0 || err_underflow !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_fifo: got valid=%b id=%0d err=%b want 0/0/0", m_id_valid, m_id, err_underflow); end
    rst = 1'b0;
    clear_model();
    expect_grants(4'hF, 1);
    s_axis_tvalid = 4'hF;
    for (int c = 0; c < LIM && blocks_done < 1; c++) step();
    s_axis_tvalid = '0;
    e = exp_q.pop_front(); o = -1;
    if (obs_q.size() > 0) o = obs_q.pop_front();
    n_chk++; if (o != e) begin n_fail++; $display("FAIL rst_next_grant: got ch%0d want ch%0d", o, e); end
    n_chk++; if (blocks_done != 1 || lock_err != 0) begin n_fail++; $display("FAIL rst_block_len: got blocks=%0d lock=%0d want 1/0", blocks_done, lock_err); end
  endtask

  task automatic test_two_req();
    int e, o;
    do_reset();
    expect_grants(4'b1001, 3);
    s_axis_tvalid = 4'b1001; enc_tready = 1'b1;
    for (int c = 0; c < LIM && blocks_done < 3; c++) step();
    s_axis_tvalid = '0;
    n_chk++; if (blocks_done != 3) begin n_fail++; $display("FAIL two_blocks: got %0d want 3", blocks_done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = -1;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_chk++; if (o != e) begin n_fail++; $display("FAIL two_grant: got ch%0d want ch%0d", o, e); end
    end
  endtask

  initial begin
    clear_model();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_stall();
    test_hold();
    test_fifo_full();
    test_underflow_reset();
    test_two_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/enc_arbiter.md
ENC_ARBITER -- requirements
Module: enc_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of bit-serial requester channels (2..8).
REQ-002 SHALL have parameter K_BITS, default 7136: information bits per codeblock.
REQ-003 SHALL have parameter ID_DEPTH, default 4: channel-ID FIFO depth (power of 2).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axis_tdata  input  N_CH  per-channel serial info bit.
REQ-007 SHALL have port s_axis_tvalid  input  N_CH  per-channel bit valid.
REQ-008 SHALL have port s_axis_tready  output  N_CH  per-channel bit accept.
REQ-009 SHALL have port enc_tdata  output  1  bit to encoder input.
REQ-010 SHALL have port enc_tvalid  output  1  valid to encoder input.
REQ-011 SHALL have port enc_tready  input  1  encoder input ready.
REQ-012 SHALL have port enc_out_tvalid  input  1  encoder output valid (monitor only).
REQ-013 SHALL have port enc_out_tready  input  1  downstream ready on encoder output (monitor only).
REQ-014 SHALL have port enc_out_tlast  input  1  encoder codeblock-end flag (monitor only).
REQ-015 SHALL have port m_id  output  clog2(N_CH)  channel owning the codeblock currently leaving the encoder.
REQ-016 SHALL have port m_id_valid  output  1  m_id meaningful (ID FIFO not empty).
REQ-017 SHALL have port busy  output  1  high in state STREAM.
REQ-018 SHALL have port err_underflow  output  1  sticky: tlast seen with ID FIFO empty.

Function
REQ-019 SHALL implement states IDLE and STREAM.
REQ-020 IDLE: when any s_axis_tvalid bit is high and ID FIFO not full, SHALL select a winner, register grant, push winner ID into FIFO, go to STREAM next cycle.
REQ-021 IDLE with ID FIFO full SHALL grant nothing; all s_axis_tready low.
REQ-022 Winner selection SHALL be round-robin: first requesting channel scanning upward from (last_grant+1) mod N_CH; last_grant resets to N_CH-1 so channel 0 wins first.
REQ-023 STREAM: enc_tdata=s_axis_tdata[g], enc_tvalid=s_axis_tvalid[g], s_axis_tready[g]=enc_tready, combinational, zero latency; all non-granted s_axis_tready low.
REQ-024 In IDLE, enc_tvalid SHALL be 0 and enc_tdata 0.
REQ-025 Bit counter SHALL increment on each enc_tvalid&&enc_tready in STREAM; grant locked until K_BITS bits transferred.
REQ-026 On handshake with counter==K_BITS-1: counter->0, last_grant->g, state->IDLE; one idle cycle between consecutive blocks.
REQ-027 Granted channel dropping tvalid mid-block SHALL NOT release grant; stall only.
REQ-028 ID FIFO SHALL pop on enc_out_tvalid&&enc_out_tready&&enc_out_tlast.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged and both take effect.
REQ-030 Pop while empty SHALL be ignored and set err_underflow until reset.
REQ-031 m_id SHALL equal FIFO head; m_id_valid = FIFO non-empty.

Reset
REQ-032 On rst: state IDLE, counter 0, last_grant N_CH-1, FIFO empty, m_id 0, m_id_valid 0, busy 0, err_underflow 0, all s_axis_tready 0, enc_tvalid 0, enc_tdata 0.
REQ-033 rst mid-block SHALL abandon the block without completing the count; encoder shares the same rst.

Configuration
REQ-034 Macro ENC_ARB_FIXED_PRIO_EN: defined -> winner is lowest-index requesting channel, last_grant unused; undefined -> round-robin per REQ-022.

Verification
REQ-035 Ch0-3 all valid continuously, enc_tready=1 -> grants 0,1,2,3,0 each for 7136 handshakes, exactly one idle cycle between blocks, m_id pushes 0,1,2,3.
REQ-036 Only ch2 valid; enc_tready toggles 1/0 -> ch2 holds grant, block ends after 7136 accepted bits, s_axis_tready[0,1,3]=0 throughout.
REQ-037 Ch1 drops tvalid for 50 cycles at bit 3000 while ch3 requests -> grant stays ch1, counter frozen, ch3 granted only after ch1 bit 7135.
REQ-038 Encoder output stalled (no tlast) with 5 blocks requested, ID_DEPTH=4 -> 4 grants then IDLE with tready all 0; one tlast pop -> 5th grant next cycle.
REQ-039 tlast pulse with FIFO empty -> err_underflow=1, m_id_valid=0; rst at bit 4000 of block -> all outputs at reset values next cycle, next grant ch0.
REQ-040 ENC_ARB_FIXED_PRIO_EN defined, ch0 and ch3 continuously valid -> ch0 granted every block, ch3 never.
